// File: rtl/core_onchip_mem_dp_pkg.sv
// Shared types, constants and helpers for the dual-port per-core on-chip RAM.
package core_mem_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_t;

  localparam int COLL_CNT_W = 32'sd16;

  function automatic int be_w(input int data_w);
    return data_w / 32'sd8;
  endfunction

endpackage

// File: rtl/core_onchip_mem_dp_if.sv
// Avalon-MM port bundle for core_onchip_mem_dp; one instance per RAM port.
interface core_onchip_mem_dp_if #(
  parameter int ADDR_W = 32'sd13,
  parameter int DATA_W = 32'sd32
);

  logic [ADDR_W-1:0]                     address;
  logic                                  chipselect;
  logic                                  read;
  logic                                  write;
  logic [core_mem_pkg::be_w(DATA_W)-1:0] byteenable;
  logic [DATA_W-1:0]                     writedata;
  logic [DATA_W-1:0]                     readdata;
  logic                                  readdatavalid;
  logic                                  waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/core_onchip_mem_dp_rd_pipe.sv
// Per-port read-return pipeline: one stage, or two when CORE_MEM_OUTREG_EN is defined.
module core_mem_rd_pipe #(
  parameter int DATA_W = 32'sd32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              rd_fire,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  logic              s1_vld_r;
  logic [DATA_W-1:0] s1_data_r;

  // First stage captures RAM data at accept time and freezes while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_r  <= 1'b0;
      s1_data_r <= '0;
    end else if (en) begin
      s1_vld_r <= rd_fire;
      if (rd_fire) begin
        s1_data_r <= rd_data;
      end
    end
  end

`ifdef CORE_MEM_OUTREG_EN
  logic              s2_vld_r;
  logic [DATA_W-1:0] s2_data_r;

  // Optional output register stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld_r  <= 1'b0;
      s2_data_r <= '0;
    end else if (en) begin
      s2_vld_r <= s1_vld_r;
      if (s1_vld_r) begin
        s2_data_r <= s1_data_r;
      end
    end
  end

  assign readdata      = s2_data_r;
  assign readdatavalid = s2_vld_r & en;
`else
  assign readdata      = s1_data_r;
  assign readdatavalid = s1_vld_r & en;
`endif

endmodule

// File: rtl/core_onchip_mem_dp.sv
// True-dual-port Avalon-MM on-chip RAM with same-address write arbitration and optional zero-fill.
// Define CORE_MEM_OUTREG_EN for an extra read output register per port (read latency 2).
module core_onchip_mem_dp
  import core_mem_pkg::*;
#(
  parameter int    DATA_W         = 32'sd32,
  parameter int    ADDR_W         = 32'sd13,
  parameter int    DEPTH          = 32'sd8192,
  parameter string INIT_FILE      = "core_onchip_mem_dp.hex",
  parameter int    CLEAR_ON_RESET = 32'sd0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  reset_req,
  core_onchip_mem_dp_if.slave   a,
  core_onchip_mem_dp_if.slave   b,
  output logic                  init_done,
  output logic [COLL_CNT_W-1:0] coll_cnt
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int IDX_W = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 32'sd1;

  localparam logic [ADDR_W:0]  DEPTH_C    = (ADDR_W + 32'sd1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(DEPTH - 32'sd1);
  localparam logic [0:0]       ST_CLEAR   = CLEAR;
  localparam logic [0:0]       ST_RUN     = RUN;

  logic [0:0]            state_r;
  logic [IDX_W-1:0]      clr_idx_r;
  logic [COLL_CNT_W-1:0] coll_cnt_r;
  logic [DATA_W-1:0]     mem_r [DEPTH];

  logic              en_s, run_s, wait_s, clearing_s;
  logic              a_acc_s, a_wr_s, a_rd_s, a_in_s;
  logic              b_acc_s, b_wr_s, b_rd_s, b_in_s;
  logic              coll_s, a_wr_keep_s, b_wr_keep_s;
  logic [IDX_W-1:0]  a_idx_s, b_idx_s;
  logic [DATA_W-1:0] a_rdata_s, b_rdata_s;

  // Request decode, range check and same-address write arbitration (port A wins).
  always_comb begin
    en_s       = clken & ~reset_req;
    run_s      = (state_r == ST_RUN);
    wait_s     = ~(run_s & en_s);
    clearing_s = (CLEAR_ON_RESET != 32'sd0) & ~run_s & en_s;

    a_acc_s = a.chipselect & (a.read | a.write) & ~wait_s;
    a_wr_s  = a_acc_s & a.write;
    a_rd_s  = a_acc_s & a.read & ~a.write;
    a_in_s  = ({1'b0, a.address} < DEPTH_C);
    a_idx_s = a.address[IDX_W-1:0];

    b_acc_s = b.chipselect & (b.read | b.write) & ~wait_s;
    b_wr_s  = b_acc_s & b.write;
    b_rd_s  = b_acc_s & b.read & ~b.write;
    b_in_s  = ({1'b0, b.address} < DEPTH_C);
    b_idx_s = b.address[IDX_W-1:0];

    coll_s      = a_wr_s & b_wr_s & (a.address == b.address);
    a_wr_keep_s = a_wr_s & a_in_s;
    b_wr_keep_s = b_wr_s & b_in_s & ~coll_s;

    // Out-of-range reads return zero rather than aliased contents.
    a_rdata_s = a_in_s ? mem_r[a_idx_s] : '0;
    b_rdata_s = b_in_s ? mem_r[b_idx_s] : '0;
  end

  // RAM array: zero-fill while clearing, otherwise byte-lane writes from both ports.
  always_ff @(posedge clk) begin
    if (clearing_s) begin
      mem_r[clr_idx_r] <= '0;
    end else begin
      for (int i = 32'sd0; i < BE_W; i++) begin
        if (b_wr_keep_s && b.byteenable[i]) begin
          mem_r[b_idx_s][i*8 +: 8] <= b.writedata[i*8 +: 8];
        end
        if (a_wr_keep_s && a.byteenable[i]) begin
          mem_r[a_idx_s][i*8 +: 8] <= a.writedata[i*8 +: 8];
        end
      end
    end
  end

  // Init FSM and clear address; both freeze while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_CLEAR;
      clr_idx_r <= '0;
    end else if (en_s) begin
      case (state_r)
        ST_CLEAR: begin
          if ((CLEAR_ON_RESET == 32'sd0) || (clr_idx_r == LAST_IDX_C)) begin
            state_r <= ST_RUN;
          end else begin
            clr_idx_r <= clr_idx_r + 1'b1;
          end
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_CLEAR;
      endcase
    end
  end

  // Saturating count of dropped port-B writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coll_cnt_r <= '0;
    end else if (coll_s && (coll_cnt_r != {COLL_CNT_W{1'b1}})) begin
      coll_cnt_r <= coll_cnt_r + 1'b1;
    end
  end

  core_mem_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe_a (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (en_s),
    .rd_fire       (a_rd_s),
    .rd_data       (a_rdata_s),
    .readdata      (a.readdata),
    .readdatavalid (a.readdatavalid)
  );

  core_mem_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe_b (
    .clk           (clk),
    .reset_n       (reset_n),
    .en            (en_s),
    .rd_fire       (b_rd_s),
    .rd_data       (b_rdata_s),
    .readdata      (b.readdata),
    .readdatavalid (b.readdatavalid)
  );

  assign a.waitrequest = wait_s;
  assign b.waitrequest = wait_s;
  assign init_done     = run_s;
  assign coll_cnt      = coll_cnt_r;

endmodule

// File: tb/tb_core_onchip_mem_dp.sv
// Self-checking bench for core_onchip_mem_dp: random and directed traffic against a cycle-level memory model.
module tb_core_onchip_mem_dp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
`ifdef CORE_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b1;
  logic        clken     = 1'b1;
  logic        reset_req = 1'b0;
  logic        init_done, init_done_c;
  logic [15:0] coll_cnt, coll_cnt_c;

  core_onchip_mem_dp_if #(.ADDR_W(AW), .DATA_W(DW)) pa ();
  core_onchip_mem_dp_if #(.ADDR_W(AW), .DATA_W(DW)) pb ();
  core_onchip_mem_dp_if #(.ADDR_W(4),  .DATA_W(DW)) ca ();
  core_onchip_mem_dp_if #(.ADDR_W(4),  .DATA_W(DW)) cb ();

  always #5 clk = ~clk;

  core_onchip_mem_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(0)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .a(pa), .b(pb), .init_done(init_done), .coll_cnt(coll_cnt)
  );

  core_onchip_mem_dp #(.DATA_W(DW), .ADDR_W(4), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut_clr (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .a(ca), .b(cb), .init_done(init_done_c), .coll_cnt(coll_cnt_c)
  );

  typedef struct packed { int due; logic [31:0] data; } rsp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rdv_cnt_a = 0;
  logic [31:0] mem_m [DEPTH];
  bit          run_m;
  int          ecnt = 0;
  logic [15:0] coll_m;
  rsp_t        qa[$];
  rsp_t        qb[$];

  always @(negedge clk) if (pa.readdatavalid === 1'b1) rdv_cnt_a++;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  task automatic drive_a(bit cs, bit rd, bit wr, logic [4:0] addr, logic [3:0] be, logic [31:0] wd);
    pa.chipselect = cs; pa.read = rd; pa.write = wr;
    pa.address = addr; pa.byteenable = be; pa.writedata = wd;
  endtask

  task automatic drive_b(bit cs, bit rd, bit wr, logic [4:0] addr, logic [3:0] be, logic [31:0] wd);
    pb.chipselect = cs; pb.read = rd; pb.write = wr;
    pb.address = addr; pb.byteenable = be; pb.writedata = wd;
  endtask

  task automatic idle();
    drive_a(1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
    drive_b(1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    coll_m = 16'd0;
    run_m  = 1'b0;
  endtask

  // One clock of the reference model: check outputs for this cycle, then apply this cycle's requests.
  task automatic cycle();
    bit en, ev_a, ev_b, wa, wb, ra, rb;
    logic [31:0] rd_a, rd_b;
    #1;
    en = clken && !reset_req;
    n_checks++;
    if (pa.waitrequest !== !(run_m && en) || pb.waitrequest !== !(run_m && en)) begin
      n_fail++; $display("FAIL waitrequest t=%0t got a=%b b=%b exp=%b", $time, pa.waitrequest, pb.waitrequest, !(run_m && en));
    end
    n_checks++;
    if (init_done !== run_m) begin
      n_fail++; $display("FAIL init_done t=%0t got=%b exp=%b", $time, init_done, run_m);
    end
    n_checks++;
    if (coll_cnt !== coll_m) begin
      n_fail++; $display("FAIL coll_cnt t=%0t got=%0d exp=%0d", $time, coll_cnt, coll_m);
    end
    ev_a = en && (qa.size() > 0) && (qa[0].due <= ecnt + 1);
    ev_b = en && (qb.size() > 0) && (qb[0].due <= ecnt + 1);
    n_checks++;
    if (pa.readdatavalid !== ev_a) begin
      n_fail++; $display("FAIL rdv_a t=%0t got=%b exp=%b", $time, pa.readdatavalid, ev_a);
    end
    n_checks++;
    if (pb.readdatavalid !== ev_b) begin
      n_fail++; $display("FAIL rdv_b t=%0t got=%b exp=%b", $time, pb.readdatavalid, ev_b);
    end
    if (ev_a) begin
      n_checks++;
      if (pa.readdata !== qa[0].data) begin
        n_fail++; $display("FAIL rdata_a t=%0t got=%h exp=%h", $time, pa.readdata, qa[0].data);
      end
      void'(qa.pop_front());
    end
    if (ev_b) begin
      n_checks++;
      if (pb.readdata !== qb[0].data) begin
        n_fail++; $display("FAIL rdata_b t=%0t got=%h exp=%h", $time, pb.readdata, qb[0].data);
      end
      void'(qb.pop_front());
    end
    wa = en && run_m && pa.chipselect && pa.write;
    ra = en && run_m && pa.chipselect && pa.read && !pa.write;
    wb = en && run_m && pb.chipselect && pb.write;
    rb = en && run_m && pb.chipselect && pb.read && !pb.write;
    rd_a = (int'(pa.address) < DEPTH) ? mem_m[pa.address[3:0]] : 32'h0;
    rd_b = (int'(pb.address) < DEPTH) ? mem_m[pb.address[3:0]] : 32'h0;
    if (ra) qa.push_back('{due: ecnt + 1 + LAT, data: rd_a});
    if (rb) qb.push_back('{due: ecnt + 1 + LAT, data: rd_b});
    if (wa && wb && pa.address == pb.address) begin
      wb = 1'b0;
      if (coll_m != 16'hFFFF) coll_m++;
    end
    if (wb && int'(pb.address) < DEPTH)
      mem_m[pb.address[3:0]] = merge(mem_m[pb.address[3:0]], pb.writedata, pb.byteenable);
    if (wa && int'(pa.address) < DEPTH)
      mem_m[pa.address[3:0]] = merge(mem_m[pa.address[3:0]], pa.writedata, pa.byteenable);
    if (en) begin
      ecnt++;
      run_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pa.readdata !== 32'h0 || pb.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata got a=%h b=%h exp=0", pa.readdata, pb.readdata);
    end
    n_checks++;
    if (pa.readdatavalid !== 1'b0 || pb.readdatavalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdv got a=%b b=%b exp=0", pa.readdatavalid, pb.readdatavalid);
    end
    n_checks++;
    if (pa.waitrequest !== 1'b1 || pb.waitrequest !== 1'b1 || ca.waitrequest !== 1'b1) begin
      n_fail++; $display("FAIL reset_wait got a=%b b=%b c=%b exp=1", pa.waitrequest, pb.waitrequest, ca.waitrequest);
    end
    n_checks++;
    if (init_done !== 1'b0 || init_done_c !== 1'b0 || coll_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_status got init=%b init_c=%b coll=%0d exp 0/0/0", init_done, init_done_c, coll_cnt);
    end
    model_reset();
    reset_n = 1'b1;
  endtask

  task automatic test_clear();
    int cnt = 0;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (ca.waitrequest !== 1'b1 || init_done_c !== 1'b0) begin
        n_fail++; $display("FAIL clear_busy cycle=%0d got wait=%b init=%b exp 1/0", k, ca.waitrequest, init_done_c);
      end
      cycle();
    end
    n_checks++;
    if (ca.waitrequest !== 1'b0 || init_done_c !== 1'b1) begin
      n_fail++; $display("FAIL clear_done got wait=%b init=%b exp 0/1", ca.waitrequest, init_done_c);
    end
    for (int k = 0; k < 16 + LAT + 2; k++) begin
      ca.chipselect = (k < 16); ca.read = (k < 16); ca.address = 4'(k);
      cycle();
      if (ca.readdatavalid === 1'b1) begin
        cnt++;
        n_checks++;
        if (ca.readdata !== 32'h0) begin
          n_fail++; $display("FAIL clear_data got=%h exp=0", ca.readdata);
        end
      end
    end
    ca.chipselect = 1'b0; ca.read = 1'b0;
    n_checks++;
    if (cnt != 16) begin
      n_fail++; $display("FAIL clear_reads got=%0d exp=16", cnt);
    end
  endtask

  task automatic test_init();
    for (int i = 0; i < DEPTH; i++) begin
      drive_a(1'b1, 1'b0, 1'b1, 5'(i), 4'hF, $urandom);
      cycle();
    end
    idle();
  endtask

  task automatic test_byte_lanes();
    drive_a(1'b1, 1'b0, 1'b1, 5'd5, 4'hF, 32'h0); cycle();
    drive_a(1'b1, 1'b0, 1'b1, 5'd5, 4'b0101, 32'hDEADBEEF); cycle();
    drive_a(1'b1, 1'b0, 1'b1, 5'd5, 4'b0000, 32'hFFFFFFFF); cycle();
    drive_a(1'b1, 1'b1, 1'b0, 5'd5, 4'h0, 32'h0); cycle();
    idle();
    repeat (LAT - 1) cycle();
    n_checks++;
    if (pa.readdatavalid !== 1'b1 || pa.readdata !== 32'h00AD00EF) begin
      n_fail++; $display("FAIL byte_lanes got v=%b d=%h exp v=1 d=00ad00ef", pa.readdatavalid, pa.readdata);
    end
    repeat (2) cycle();
  endtask

  task automatic test_collision();
    drive_a(1'b1, 1'b0, 1'b1, 5'd7, 4'hF, 32'h11111111);
    drive_b(1'b1, 1'b0, 1'b1, 5'd7, 4'hF, 32'h22222222);
    cycle();
    idle();
    n_checks++;
    if (coll_cnt !== 16'd1) begin
      n_fail++; $display("FAIL coll_first got=%0d exp=1", coll_cnt);
    end
    drive_a(1'b1, 1'b1, 1'b0, 5'd7, 4'h0, 32'h0); cycle();
    idle();
    repeat (LAT - 1) cycle();
    n_checks++;
    if (pa.readdatavalid !== 1'b1 || pa.readdata !== 32'h11111111) begin
      n_fail++; $display("FAIL coll_winner got v=%b d=%h exp v=1 d=11111111", pa.readdatavalid, pa.readdata);
    end
    repeat (2) cycle();
  endtask

  task automatic test_rd_during_wr();
    drive_a(1'b1, 1'b0, 1'b1, 5'd3, 4'hF, 32'h12345678); cycle();
    drive_a(1'b1, 1'b0, 1'b1, 5'd3, 4'hF, 32'hAAAA0000);
    drive_b(1'b1, 1'b1, 1'b0, 5'd3, 4'h0, 32'h0);
    cycle();
    idle();
    repeat (LAT - 1) cycle();
    n_checks++;
    if (pb.readdatavalid !== 1'b1 || pb.readdata !== 32'h12345678) begin
      n_fail++; $display("FAIL rbw_old got v=%b d=%h exp v=1 d=12345678", pb.readdatavalid, pb.readdata);
    end
    drive_b(1'b1, 1'b1, 1'b0, 5'd3, 4'h0, 32'h0); cycle();
    idle();
    repeat (LAT - 1) cycle();
    n_checks++;
    if (pb.readdatavalid !== 1'b1 || pb.readdata !== 32'hAAAA0000) begin
      n_fail++; $display("FAIL rbw_new got v=%b d=%h exp v=1 d=aaaa0000", pb.readdatavalid, pb.readdata);
    end
    repeat (2) cycle();
  endtask

  task automatic test_back_to_back();
    int start = rdv_cnt_a;
    drive_a(1'b1, 1'b1, 1'b0, 5'd1, 4'h0, 32'h0); cycle();
    drive_a(1'b1, 1'b1, 1'b0, 5'd2, 4'h0, 32'h0); cycle();
    clken = 1'b0;
    drive_a(1'b1, 1'b1, 1'b0, 5'd4, 4'h0, 32'h0);
    repeat (3) begin
      cycle();
      n_checks++;
      if (pa.readdatavalid !== 1'b0) begin
        n_fail++; $display("FAIL stall_rdv got=%b exp=0", pa.readdatavalid);
      end
    end
    clken = 1'b1;
    cycle();
    drive_a(1'b1, 1'b1, 1'b0, 5'd6, 4'h0, 32'h0); cycle();
    idle();
    repeat (LAT + 2) cycle();
    n_checks++;
    if (rdv_cnt_a - start != 4) begin
      n_fail++; $display("FAIL b2b_pulses got=%0d exp=4", rdv_cnt_a - start);
    end
  endtask

  task automatic test_reset_in_flight();
    int start;
    drive_a(1'b1, 1'b1, 1'b0, 5'd2, 4'h0, 32'h0); cycle();
    idle();
    start = rdv_cnt_a;
    reset_n = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      n_checks++;
      if (pa.readdatavalid !== 1'b0 || coll_cnt !== 16'd0) begin
        n_fail++; $display("FAIL inflight_reset got v=%b coll=%0d exp 0/0", pa.readdatavalid, coll_cnt);
      end
    end
    reset_n = 1'b1;
    repeat (LAT + 2) cycle();
    n_checks++;
    if (rdv_cnt_a != start) begin
      n_fail++; $display("FAIL inflight_drop got=%0d exp=%0d", rdv_cnt_a, start);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive_a(1'b1, 1'b1, 1'b0, 5'(i), 4'h0, 32'h0);
      drive_b(1'b1, 1'b1, 1'b0, 5'(DEPTH - 1 - i), 4'h0, 32'h0);
      cycle();
    end
    idle();
    repeat (LAT + 1) cycle();
  endtask

  task automatic test_random();
    logic [4:0] addr_a, addr_b;
    for (int k = 0; k < 400; k++) begin
      clken     = ($urandom_range(0, 9) != 0);
      reset_req = ($urandom_range(0, 19) == 0);
      addr_a = 5'($urandom_range(0, 19));
      addr_b = ($urandom_range(0, 3) == 0) ? addr_a : 5'($urandom_range(0, 19));
      drive_a(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              addr_a, 4'($urandom), $urandom);
      drive_b(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              addr_b, 4'($urandom), $urandom);
      cycle();
    end
    clken = 1'b1;
    reset_req = 1'b0;
    idle();
    repeat (LAT + 2) cycle();
  endtask

  initial begin
    idle();
    ca.chipselect = 1'b0; ca.read = 1'b0; ca.write = 1'b0; ca.address = 4'd0;
    ca.byteenable = 4'h0; ca.writedata = 32'h0;
    cb.chipselect = 1'b0; cb.read = 1'b0; cb.write = 1'b0; cb.address = 4'd0;
    cb.byteenable = 4'h0; cb.writedata = 32'h0;
    #2;
    test_reset();
    test_clear();
    test_init();
    test_byte_lanes();
    test_collision();
    test_rd_during_wr();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
